// File: rtl/time_entry_loader.sv
`timescale 1ns/1ps
// time_entry_loader: collects up to three keypad digits as M:SS, validates
// them, and drives the timer chain's parallel load bus with a single
// active-low load strobe. After loading, it locks out entry until the timer
// reaches zero or the user cancels.
module time_entry_loader #(
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  input  logic       cancel,
  input  logic       timer_zero,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
  output logic       loadn,
  output logic [1:0] digit_count,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ENTRY = 2'b01,
    LOAD  = 2'b10,
    RUN   = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic       keyPrev_q, startPrev_q;
  logic [3:0] secOnes_q, secOnes_d;
  logic [3:0] secTens_q, secTens_d;
  logic [3:0] mins_q, mins_d;
  logic [1:0] digitCount_q, digitCount_d;
  logic       loadn_q, loadn_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  logic keyEvent;
  logic startEvent;
  logic bufferZero;
  logic keyReject;

  assign keyEvent   = key_valid & ~keyPrev_q;
  assign startEvent = start & ~startPrev_q;
  assign bufferZero = (secOnes_q == 4'd0) && (secTens_q == 4'd0) && (mins_q == 4'd0);

  // A key is refused when it is not a decimal digit, the buffer is full, or
  // shifting would push a value above 5 into the seconds-tens position.
  assign keyReject = (key_code > 4'd9)
                  || (digitCount_q == 2'(MAX_DIGITS))
                  || ((digitCount_q != 2'd0) && (secOnes_q > 4'd5));

  // State, buffer and output registers; reset returns everything to idle.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q      <= IDLE;
      keyPrev_q    <= 1'b0;
      startPrev_q  <= 1'b0;
      secOnes_q    <= 4'd0;
      secTens_q    <= 4'd0;
      mins_q       <= 4'd0;
      digitCount_q <= 2'd0;
      loadn_q      <= 1'b1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      keyPrev_q    <= key_valid;
      startPrev_q  <= start;
      secOnes_q    <= secOnes_d;
      secTens_q    <= secTens_d;
      mins_q       <= mins_d;
      digitCount_q <= digitCount_d;
      loadn_q      <= loadn_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic: cancel beats start, start beats a key in the same cycle.
  always_comb begin
    state_d      = state_q;
    secOnes_d    = secOnes_q;
    secTens_d    = secTens_q;
    mins_d       = mins_q;
    digitCount_d = digitCount_q;
    loadn_d      = 1'b1;
    err_d        = 1'b0;

    if (cancel) begin
      secOnes_d    = 4'd0;
      secTens_d    = 4'd0;
      mins_d       = 4'd0;
      digitCount_d = 2'd0;
      state_d      = IDLE;
    end else begin
      case (state_q)
        IDLE, ENTRY: begin
          if ((state_q == ENTRY) && startEvent) begin
            if (bufferZero) begin
              err_d        = 1'b1;
              secOnes_d    = 4'd0;
              secTens_d    = 4'd0;
              mins_d       = 4'd0;
              digitCount_d = 2'd0;
              state_d      = IDLE;
            end else begin
              state_d = LOAD;
            end
          end else if (keyEvent) begin
            if (keyReject) begin
              err_d = 1'b1;
            end else begin
              mins_d       = secTens_q;
              secTens_d    = secOnes_q;
              secOnes_d    = key_code;
              digitCount_d = digitCount_q + 2'd1;
              state_d      = ENTRY;
            end
          end
        end
        LOAD: begin
          if (loadn_q) begin
            loadn_d = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (timer_zero) begin
            secOnes_d    = 4'd0;
            secTens_d    = 4'd0;
            mins_d       = 4'd0;
            digitCount_d = 2'd0;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == LOAD) || (state_d == RUN);
  end

  assign sec_ones    = secOnes_q;
  assign sec_tens    = secTens_q;
  assign mins        = mins_q;
  assign loadn       = loadn_q;
  assign digit_count = digitCount_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_time_entry_loader.sv
`timescale 1ns/1ps
// Testbench for time_entry_loader: directed scenarios followed by random
// stimulus, all checked every cycle against a digit-queue reference model.
module tb_time_entry_loader;

  logic       clk;
  logic       clearn;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start;
  logic       cancel;
  logic       timer_zero;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] mins;
  logic       loadn;
  logic [1:0] digit_count;
  logic       busy;
  logic       err;

  int checkCount;
  int passCount;

  // Reference model: the buffer is the list of accepted digits, newest last.
  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_LOAD  = 2;
  localparam int M_RUN   = 3;

  int   mDigits[$];
  int   mMode;
  bit   mStrobed;
  bit   mPrevKey;
  bit   mPrevStart;
  bit   mErr;
  bit   mLoadn;

  time_entry_loader #(.MAX_DIGITS(3)) dut (
    .clk         (clk),
    .clearn      (clearn),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .start       (start),
    .cancel      (cancel),
    .timer_zero  (timer_zero),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .mins        (mins),
    .loadn       (loadn),
    .digit_count (digit_count),
    .busy        (busy),
    .err         (err)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int digitAt(int fromEnd);
    if (mDigits.size() > fromEnd) return mDigits[mDigits.size() - 1 - fromEnd];
    return 0;
  endfunction

  function automatic int bufferSeconds();
    return digitAt(2) * 60 + digitAt(1) * 10 + digitAt(0);
  endfunction

  task automatic modelReset();
    mDigits.delete();
    mMode      = M_IDLE;
    mStrobed   = 1'b0;
    mPrevKey   = 1'b0;
    mPrevStart = 1'b0;
    mErr       = 1'b0;
    mLoadn     = 1'b1;
  endtask

  // One rising edge of the reference model, using the inputs currently applied.
  task automatic modelStep();
    bit keyEv;
    bit startEv;
    keyEv      = key_valid && !mPrevKey;
    startEv    = start && !mPrevStart;
    mPrevKey   = key_valid;
    mPrevStart = start;
    mErr       = 1'b0;
    mLoadn     = 1'b1;
    if (cancel) begin
      mDigits.delete();
      mMode = M_IDLE;
    end else if (mMode == M_IDLE || mMode == M_ENTRY) begin
      if (mMode == M_ENTRY && startEv) begin
        if (bufferSeconds() == 0) begin
          mErr = 1'b1;
          mDigits.delete();
          mMode = M_IDLE;
        end else begin
          mMode    = M_LOAD;
          mStrobed = 1'b0;
        end
      end else if (keyEv) begin
        if (key_code > 9 || mDigits.size() == 3 || (mDigits.size() >= 1 && digitAt(0) > 5)) begin
          mErr = 1'b1;
        end else begin
          mDigits.push_back(int'(key_code));
          mMode = M_ENTRY;
        end
      end
    end else if (mMode == M_LOAD) begin
      if (!mStrobed) begin
        mLoadn   = 1'b0;
        mStrobed = 1'b1;
      end else begin
        mMode = M_RUN;
      end
    end else if (timer_zero) begin
      mDigits.delete();
      mMode = M_IDLE;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".sec_ones"}, 8'(sec_ones), 8'(digitAt(0)));
    checkOutput({tag, ".sec_tens"}, 8'(sec_tens), 8'(digitAt(1)));
    checkOutput({tag, ".mins"}, 8'(mins), 8'(digitAt(2)));
    checkOutput({tag, ".digit_count"}, 8'(digit_count), 8'(mDigits.size()));
    checkOutput({tag, ".loadn"}, 8'(loadn), 8'(mLoadn));
    checkOutput({tag, ".busy"}, 8'(busy), 8'(mMode == M_LOAD || mMode == M_RUN));
    checkOutput({tag, ".err"}, 8'(err), 8'(mErr));
  endtask

  // Apply one cycle of inputs at the falling edge, clock it, then compare.
  task automatic applyStimulus(input string tag, input bit kv, input logic [3:0] kc,
                               input bit st, input bit cn, input bit tz);
    @(negedge clk);
    key_valid  = kv;
    key_code   = kc;
    start      = st;
    cancel     = cn;
    timer_zero = tz;
    @(posedge clk);
    modelStep();
    #1;
    checkAll(tag);
  endtask

  task automatic pressKey(input string tag, input logic [3:0] kc);
    applyStimulus(tag, 1'b1, kc, 1'b0, 1'b0, 1'b0);
    applyStimulus(tag, 1'b0, kc, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idleCycles(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    @(negedge clk);
    key_valid  = 1'b0;
    key_code   = 4'd0;
    start      = 1'b0;
    cancel     = 1'b0;
    timer_zero = 1'b0;
    clearn     = 1'b0;
    modelReset();
    #1;
    checkAll("reset");
    @(negedge clk);
    clearn = 1'b1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    clearn     = 1'b0;
    key_valid  = 1'b0;
    key_code   = 4'd0;
    start      = 1'b0;
    cancel     = 1'b0;
    timer_zero = 1'b0;
    modelReset();
    doReset();

    // Keys 1,3,0 then start: 1:30 loaded with a single strobe, then run to zero.
    pressKey("k130", 4'd1);
    pressKey("k130", 4'd3);
    pressKey("k130", 4'd0);
    applyStimulus("start130", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("load130", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("load130", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    idleCycles("run130", 3);
    pressKey("runKey", 4'd4);
    applyStimulus("runStart", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("runStart", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus("zero130", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idleCycles("after130", 2);

    // Four keys: the fourth overflows the buffer and is rejected.
    pressKey("k2457", 4'd2);
    pressKey("k2457", 4'd4);
    pressKey("k2457", 4'd5);
    pressKey("k2457", 4'd7);
    applyStimulus("cancel245", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    // 8 then 1: 8 cannot become a seconds-tens digit; start loads 0:08
    // while a stale timer_zero is still high.
    pressKey("k81", 4'd8);
    pressKey("k81", 4'd1);
    applyStimulus("start008", 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus("load008", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus("load008", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus("run008", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idleCycles("after008", 2);

    // Zero buffer start is refused; illegal key code is refused.
    pressKey("k0", 4'd0);
    applyStimulus("start0", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("start0", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    pressKey("k12", 4'd12);
    pressKey("k12", 4'd15);

    // Key arriving together with start in ENTRY is dropped; start in IDLE ignored.
    applyStimulus("idleStart", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("idleStart", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    pressKey("k5", 4'd5);
    applyStimulus("keyWithStart", 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    idleCycles("keyWithStart", 3);
    applyStimulus("cancelRun", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    // Start and cancel together in ENTRY: cancel wins, no strobe.
    pressKey("k4", 4'd4);
    applyStimulus("startCancel", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    idleCycles("startCancel", 2);

    // Asynchronous reset in the middle of the load strobe.
    pressKey("k9", 4'd9);
    applyStimulus("start9", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("strobe9", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    #2;
    clearn = 1'b0;
    modelReset();
    #1;
    checkAll("midLoadReset");
    @(negedge clk);
    clearn = 1'b1;
    idleCycles("postReset", 2);

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      bit         kv;
      logic [3:0] kc;
      bit         st;
      bit         cn;
      bit         tz;
      kv = 1'($urandom_range(0, 1));
      kc = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      st = ($urandom_range(0, 9) == 0);
      cn = ($urandom_range(0, 39) == 0);
      tz = ($urandom_range(0, 5) == 0);
      applyStimulus("random", kv, kc, st, cn, tz);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
